updown_mod_counter: RTL
=======================

# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and selectable wrap or saturate behaviour. It generalises the team's 3-bit down counter: any width, any modulus, and a direction selectable per cycle. It also adds terminal-count and wrap indications. It sits wherever the design needs event counting, timeout down-counting or modulo sequencing, and is fully synchronous to one clock.

## Interface
- WIDTH, 3: counter width in bits; WIDTH >= 1.
- MODULUS, 2**WIDTH: count range is 0 .. MODULUS-1.
  - Legal range: 2 <= MODULUS <= 2**WIDTH.
  - Out-of-range values fail elaboration via a generate-time check.
- SATURATE, 0: selects boundary behaviour.
  - 0 = wrap at the boundaries.
  - 1 = hold at the boundaries.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
  - Asserted (0) forces all state to reset values immediately.
- en  input  1  count enable; sampled on clk rising edge.
- up_dn  input  1  direction: 1 = count up, 0 = count down; sampled with en.
- load  input  1  synchronous parallel load; has priority over en.
- load_val  input  WIDTH  value loaded when load = 1.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from count and up_dn.
  - High when up_dn=1 and count=MODULUS-1.
  - High when up_dn=0 and count=0.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a boundary crossing.
- sat  output  1  registered; high in the cycle after a count request was blocked at a boundary (SATURATE=1 only).

## Operation
- Reset (reset=0): count=0, wrap=0, sat=0, regardless of clk.
  - tc then follows up_dn: tc=1 if up_dn=0.
- Per rising edge with reset=1, evaluate in priority order:
  1. load=1:
     - count <= min(load_val, MODULUS-1); out-of-range loads clamp to MODULUS-1.
     - wrap <= 0, sat <= 0.
     - en is ignored.
  2. en=1, up_dn=1:
     - count < MODULUS-1: count <= count+1.
     - count = MODULUS-1, SATURATE=0: count <= 0, wrap <= 1.
     - count = MODULUS-1, SATURATE=1: count holds, sat <= 1.
  3. en=1, up_dn=0:
     - count > 0: count <= count-1.
     - count = 0, SATURATE=0: count <= MODULUS-1, wrap <= 1.
     - count = 0, SATURATE=1: count holds, sat <= 1.
  4. en=0: count holds.
- In every case not listed above, wrap and sat are 0.
- Arithmetic is performed in WIDTH+1 bits internally so that MODULUS = 2**WIDTH wraps correctly with no truncation artefacts.
- A direction change while en=1 takes effect on the same edge; there is no turnaround cycle.
- tc is purely combinational: a change on up_dn changes tc in the same cycle.
- wrap and sat are never high simultaneously.
  - In SATURATE=0 mode, sat is constant 0.
  - In SATURATE=1 mode, wrap is constant 0.

## Timing
- Latency: count updates on the first rising clk edge after load/en is sampled.
  - One clock from request to new count.
  - wrap/sat appear aligned with the new (or held) count value.
- Reset assertion is asynchronous: outputs reach reset values without a clock edge.
- Reset deassertion:
  - The first rising edge with reset=1 is a normal operating edge.
  - Callers must meet recovery time; the block has no internal synchroniser.
- Reset mid-count: count returns to 0 immediately and any pending wrap/sat pulse is cleared.
- Throughput: one count step per clock when en is held high.
- Only the tc output has a combinational path from an input (up_dn).

## Test plan
- Reset: hold reset=0 with en=1, up_dn=1 across several edges, then release.
  - Required while held: count=0, wrap=0, sat=0.
  - Required after release: counting starts 0,1,2… from the first edge with reset=1.
- Modulo wrap up (WIDTH=3, MODULUS=6, SATURATE=0): en=1, up_dn=1 for 8 edges from 0.
  - count = 1,2,3,4,5,0,1,2.
  - tc=1 only while count=5.
  - wrap=1 only in the cycle count=0 after 5.
- Modulo wrap down plus direction change (same parameters): load_val=1, load=1; then en=1, up_dn=0 for 3 edges; then up_dn=1 for 2 edges.
  - count = 1,0,5,4 then 5,0.
  - wrap pulses after the 0→5 and 5→0 transitions.
- Saturate (WIDTH=3, MODULUS=6, SATURATE=1): count up from 4 for 4 edges, then down from 1 for 3 edges.
  - Up: count = 5,5,5,5, with sat=1 on the last three.
  - Down: count = 0,0,0, with sat=1 on the last two.
  - wrap stays 0 throughout.
- Load priority and clamp (WIDTH=3, MODULUS=6): load=1, en=1, load_val=7.
  - count=5 (clamped); no increment on that edge; wrap=0.
  - Next edge with load=0, en=1, up_dn=1, SATURATE=0: count=0, wrap=1.
- Full-range parameters (WIDTH=4, MODULUS=16): count down from 0 with en=1.
  - count = 15,14… with wrap on 0→15.
  - Async reset pulsed mid-sequence at count=9: count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : updown_mod_counter
// Brief   : Parametrised up/down counter with programmable modulus, parallel
//           load, count enable and selectable wrap/saturate boundaries.
//           Provides terminal-count, wrap-pulse and saturation indications.
// Revision: 1.0  initial release
// ============================================================================
module updown_mod_counter #(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 2**WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,     // asynchronous, active low
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);

   // Boundary comparisons and the load clamp are done one bit wider than the
   // counter so that MODULUS = 2**WIDTH yields a LAST that still fits and an
   // out-of-range load_val compares correctly.
   localparam int             EXT_W = WIDTH + 1;
   localparam logic [WIDTH:0] LAST  = EXT_W'(MODULUS - 1);

   // Reject illegal parameter combinations at elaboration time.
   generate
      if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_params
         $error("updown_mod_counter: require WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
      end
   endgenerate

   logic [WIDTH:0]   count_ext;
   logic [WIDTH:0]   load_ext;
   logic             at_last;
   logic             at_zero;
   logic [WIDTH-1:0] next_count;
   logic             next_wrap;
   logic             next_sat;

   assign count_ext = {1'b0, count};
   assign load_ext  = {1'b0, load_val};
   assign at_last   = (count_ext == LAST);
   assign at_zero   = (count_ext == '0);

   // Terminal count looks ahead in the currently selected direction.
   assign tc = up_dn ? at_last : at_zero;

   // Next-state selection: load beats enable; boundaries either wrap or hold.
   // Increment/decrement only happen away from the boundary, so they never
   // overflow WIDTH bits.
   always_comb begin
      next_count = count;
      next_wrap  = 1'b0;
      next_sat   = 1'b0;
      if (load) begin
         next_count = (load_ext > LAST) ? LAST[WIDTH-1:0] : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (!at_last) begin
               next_count = count + WIDTH'(1);
            end else if (SATURATE) begin
               next_sat   = 1'b1;
            end else begin
               next_count = '0;
               next_wrap  = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               next_count = count - WIDTH'(1);
            end else if (SATURATE) begin
               next_sat   = 1'b1;
            end else begin
               next_count = LAST[WIDTH-1:0];
               next_wrap  = 1'b1;
            end
         end
      end
   end

   // State register; reset clears count and any pending pulse immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else begin
         count <= next_count;
         wrap  <= next_wrap;
         sat   <= next_sat;
      end
   end

endmodule
`default_nettype wire
